// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game-flow controller.
// Holds the FSM state encoding, text overlay masks, timer reload and BCD helper.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'b00,
    ST_PLAY    = 2'b01,
    ST_NEWBALL = 2'b10,
    ST_OVER    = 2'b11
  } state_t;

  localparam logic [3:0] TEXT_SCORE = 4'b1000;
  localparam logic [3:0] TEXT_LOGO  = 4'b0100;
  localparam logic [3:0] TEXT_RULE  = 4'b0010;
  localparam logic [3:0] TEXT_OVER  = 4'b0001;

  localparam logic [3:0] TEXT_NEWGAME =
    TEXT_SCORE | TEXT_LOGO | TEXT_RULE;
  localparam logic [3:0] TEXT_PLAY = TEXT_SCORE;
  localparam logic [3:0] TEXT_END  =
    TEXT_SCORE | TEXT_OVER;

  localparam logic [6:0] TIMER_RELOAD = 7'd127;

  typedef struct packed {
    logic [3:0] dig1;
    logic [3:0] dig0;
  } score_t;

  // 2-digit BCD increment; 99 rolls over to 00.
  function automatic score_t bcd_inc(score_t s);
    score_t r;
    r = s;
    if (s.dig0 == 4'd9) begin
      r.dig0 = 4'd0;
      if (s.dig1 == 4'd9)
        r.dig1 = 4'd0;
      else
        r.dig1 = s.dig1 + 4'd1;
    end else begin
      r.dig0 = s.dig0 + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Bundle between the game controller and the rest of the pong pipeline.
// master: game/graphics/timer side; slave: the controller.
interface pong_game_ctrl_if #(
  parameter int BALL_W = 2
);

  logic [1:0]        btn;
  logic              hit;
  logic              miss;
  logic              refr_tick;
  logic              timer_up;
  logic              timer_start;
  logic              timer_tick;
  logic              gra_still;
  logic [BALL_W-1:0] ball_cnt;
  logic [3:0]        dig1;
  logic [3:0]        dig0;
  logic [3:0]        text_on;

  modport master (
    output btn,
    output hit,
    output miss,
    output refr_tick,
    output timer_up,
    input  timer_start,
    input  timer_tick,
    input  gra_still,
    input  ball_cnt,
    input  dig1,
    input  dig0,
    input  text_on
  );

  modport slave (
    input  btn,
    input  hit,
    input  miss,
    input  refr_tick,
    input  timer_up,
    output timer_start,
    output timer_tick,
    output gra_still,
    output ball_cnt,
    output dig1,
    output dig0,
    output text_on
  );

endinterface

// File: rtl/pong_score_counter.sv
// Two-digit BCD score counter: clk, reset, d_inc, d_clr in; dig1/dig0 out.
// d_clr has priority over d_inc; 99 + inc wraps to 00.
module pong_score_counter
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       d_inc,
  input  logic       d_clr,
  output logic [3:0] dig1,
  output logic [3:0] dig0
);

  score_t q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= '0;
    else if (d_clr)
      q <= '0;
    else if (d_inc)
      q <= bcd_inc(q);
  end

  assign dig1 = q.dig1;
  assign dig0 = q.dig0;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow FSM: NEWGAME/PLAY/NEWBALL/OVER, ball count and score.
// Ports: clk, reset (async high), bus (slave side of pong_game_ctrl_if).
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int NUM_BALLS = 3,
  parameter int BALL_W    = 2
) (
  input  logic clk,
  input  logic reset,
  pong_game_ctrl_if.slave bus
);

  localparam logic [BALL_W-1:0] BALLS_FULL =
    BALL_W'(NUM_BALLS);
  localparam logic [BALL_W-1:0] BALLS_FIRST =
    BALL_W'(NUM_BALLS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [BALL_W-1:0] ball_cnt;
  logic [BALL_W-1:0] ball_cnt_nxt;

  logic btn_press;
  logic miss_only;
  logic st_newgame;
  logic st_play;
  logic st_newball;
  logic st_over;

  logic       gra_still;
  logic       timer_start;
  logic [3:0] text_on;
  logic       score_inc;
  logic       score_clr;

  assign btn_press = |bus.btn;
  // A hit in the same cycle masks the miss.
  assign miss_only = bus.miss & ~bus.hit;

  assign st_newgame = (state == ST_NEWGAME);
  assign st_play    = (state == ST_PLAY);
  assign st_newball = (state == ST_NEWBALL);
  assign st_over    = (state == ST_OVER);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_NEWGAME;
      ball_cnt <= BALLS_FULL;
    end else begin
      state    <= state_nxt;
      ball_cnt <= ball_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ball_cnt_nxt = ball_cnt;
    unique case (state)
      ST_NEWGAME: begin
        ball_cnt_nxt = BALLS_FULL;
        if (btn_press) begin
          state_nxt    = ST_PLAY;
          ball_cnt_nxt = BALLS_FIRST;
        end
      end
      ST_PLAY: begin
        if (miss_only) begin
          if (ball_cnt == '0) begin
            state_nxt = ST_OVER;
          end else begin
            state_nxt    = ST_NEWBALL;
            ball_cnt_nxt = ball_cnt - 1'b1;
          end
        end
      end
      ST_NEWBALL: begin
        if (bus.timer_up && btn_press)
          state_nxt = ST_PLAY;
      end
      ST_OVER: begin
        if (bus.timer_up) begin
          state_nxt    = ST_NEWGAME;
          ball_cnt_nxt = BALLS_FULL;
        end
      end
      default: begin
        state_nxt    = ST_NEWGAME;
        ball_cnt_nxt = BALLS_FULL;
      end
    endcase
  end

  always_comb begin
    gra_still   = 1'b1;
    text_on     = TEXT_NEWGAME;
    timer_start = 1'b0;
    score_inc   = 1'b0;
    score_clr   = 1'b0;
    unique case (1'b1)
      st_newgame: begin
        score_clr = 1'b1;
      end
      st_play: begin
        gra_still   = 1'b0;
        text_on     = TEXT_PLAY;
        score_inc   = bus.hit;
        timer_start = miss_only;
      end
      st_newball: begin
        text_on = TEXT_PLAY;
      end
      st_over: begin
        text_on = TEXT_END;
      end
      default: begin
        gra_still = 1'b1;
      end
    endcase
  end

  pong_score_counter u_score (
    .clk   (clk),
    .reset (reset),
    .d_inc (score_inc),
    .d_clr (score_clr),
    .dig1  (bus.dig1),
    .dig0  (bus.dig0)
  );

  assign bus.timer_tick  = bus.refr_tick;
  assign bus.timer_start = timer_start;
  assign bus.gra_still   = gra_still;
  assign bus.text_on     = text_on;
  assign bus.ball_cnt    = ball_cnt;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl.
// Drives the master side of the interface and checks outputs 1ns after clk.
module tb_pong_game_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pong_game_ctrl_if #(.BALL_W(2)) bus ();

  pong_game_ctrl #(
    .NUM_BALLS (3),
    .BALL_W    (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_score(
    input string    tag,
    input int       d1,
    input int       d0
  );
    check({tag, ".dig1"}, 32'(bus.dig1), 32'(d1));
    check({tag, ".dig0"}, 32'(bus.dig0), 32'(d0));
  endtask

  initial begin
    reset         = 1'b1;
    bus.btn       = 2'b00;
    bus.hit       = 1'b0;
    bus.miss      = 1'b0;
    bus.refr_tick = 1'b0;
    bus.timer_up  = 1'b0;
    #1;
    check("rst.gra_still", 32'(bus.gra_still), 1);
    check("rst.text_on", 32'(bus.text_on), 32'hE);
    check("rst.timer_start", 32'(bus.timer_start), 0);
    check("rst.ball_cnt", 32'(bus.ball_cnt), 3);
    chk_score("rst", 0, 0);
    step(2);
    reset = 1'b0;
    step();
    check("ng.text_on", 32'(bus.text_on), 32'hE);

    // 1: start game
    bus.btn = 2'b01;
    step();
    bus.btn = 2'b00;
    check("t1.gra_still", 32'(bus.gra_still), 0);
    check("t1.text_on", 32'(bus.text_on), 32'h8);
    check("t1.ball_cnt", 32'(bus.ball_cnt), 2);
    bus.refr_tick = 1'b1;
    #1;
    check("t1.tick_hi", 32'(bus.timer_tick), 1);
    bus.refr_tick = 1'b0;
    #1;
    check("t1.tick_lo", 32'(bus.timer_tick), 0);

    // 2: scoring and wrap
    bus.hit = 1'b1;
    step(12);
    bus.hit = 1'b0;
    chk_score("t2.12", 1, 2);
    bus.hit = 1'b1;
    step(87);
    bus.hit = 1'b0;
    chk_score("t2.99", 9, 9);
    bus.hit = 1'b1;
    step();
    bus.hit = 1'b0;
    chk_score("t2.wrap", 0, 0);

    // 5: hit beats miss
    bus.hit  = 1'b1;
    bus.miss = 1'b1;
    #1;
    check("t5.tstart", 32'(bus.timer_start), 0);
    step();
    bus.hit  = 1'b0;
    bus.miss = 1'b0;
    chk_score("t5", 0, 1);
    check("t5.gra_still", 32'(bus.gra_still), 0);
    check("t5.ball_cnt", 32'(bus.ball_cnt), 2);

    // 3: miss -> NEWBALL, wait for timer_up
    bus.miss = 1'b1;
    #1;
    check("t3.tstart_hi", 32'(bus.timer_start), 1);
    step();
    bus.miss = 1'b0;
    #1;
    check("t3.tstart_lo", 32'(bus.timer_start), 0);
    check("t3.gra_still", 32'(bus.gra_still), 1);
    check("t3.text_on", 32'(bus.text_on), 32'h8);
    check("t3.ball_cnt", 32'(bus.ball_cnt), 1);
    bus.btn = 2'b11;
    bus.hit = 1'b1;
    step(3);
    bus.hit = 1'b0;
    check("t3.hold", 32'(bus.gra_still), 1);
    chk_score("t3.nohit", 0, 1);
    bus.btn      = 2'b10;
    bus.timer_up = 1'b1;
    step();
    bus.btn      = 2'b00;
    bus.timer_up = 1'b0;
    check("t3.play", 32'(bus.gra_still), 0);

    // 4: last ball -> OVER -> NEWGAME
    bus.miss = 1'b1;
    step();
    bus.miss = 1'b0;
    check("t4.ball_cnt0", 32'(bus.ball_cnt), 0);
    bus.btn      = 2'b01;
    bus.timer_up = 1'b1;
    step();
    bus.btn      = 2'b00;
    bus.timer_up = 1'b0;
    check("t4.play", 32'(bus.gra_still), 0);
    bus.miss = 1'b1;
    #1;
    check("t4.tstart", 32'(bus.timer_start), 1);
    step();
    bus.miss = 1'b0;
    check("t4.text_on", 32'(bus.text_on), 32'h9);
    check("t4.gra_still", 32'(bus.gra_still), 1);
    check("t4.ball_cnt", 32'(bus.ball_cnt), 0);
    bus.hit = 1'b1;
    step(2);
    bus.hit = 1'b0;
    check("t4.wait", 32'(bus.text_on), 32'h9);
    chk_score("t4.nohit", 0, 1);
    bus.timer_up = 1'b1;
    step();
    bus.timer_up = 1'b0;
    check("t4.ng_text", 32'(bus.text_on), 32'hE);
    check("t4.ng_balls", 32'(bus.ball_cnt), 3);
    step();
    chk_score("t4.clr", 0, 0);

    // 6: async reset mid-play
    bus.btn = 2'b10;
    step();
    bus.btn = 2'b00;
    bus.hit = 1'b1;
    step(37);
    bus.hit = 1'b0;
    chk_score("t6.37", 3, 7);
    check("t6.play", 32'(bus.gra_still), 0);
    #2;
    reset = 1'b1;
    #1;
    chk_score("t6.rst", 0, 0);
    check("t6.ball_cnt", 32'(bus.ball_cnt), 3);
    check("t6.gra_still", 32'(bus.gra_still), 1);
    check("t6.text_on", 32'(bus.text_on), 32'hE);
    step();
    reset = 1'b0;
    step();
    check("t6.after", 32'(bus.text_on), 32'hE);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
